// File: rtl/l2_banked_mem_arb_if.sv
// ---------------------------------------------------------------------------
// l2_banked_mem_arb_if
// Bundles the requestor-side and SRAM-bank-side buses of l2_banked_mem_arb.
//   Requestor side : req_i, gnt_o, addr_i, we_i, be_i, wdata_i,
//                    rvalid_o, rdata_o, err_o   (per port, flattened)
//   Bank side      : bank_req_o, bank_we_o, bank_addr_o, bank_be_o,
//                    bank_wdata_o, bank_rdata_i (per bank, flattened)
// modport slave  : the arbiter view (drives grants, responses, bank strobes)
// modport master : the environment view (drives requests and bank read data)
// ---------------------------------------------------------------------------
interface l2_banked_mem_arb_if #(
    parameter int unsigned NumPorts  = 4,
    parameter int unsigned NumBanks  = 8,
    parameter int unsigned BankWords = 2048,
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 64
);
    localparam int unsigned BeW  = DataWidth / 8;
    localparam int unsigned RowW = $clog2(BankWords);

    logic [NumPorts-1:0]           req_i;
    logic [NumPorts-1:0]           gnt_o;
    logic [NumPorts*AddrWidth-1:0] addr_i;
    logic [NumPorts-1:0]           we_i;
    logic [NumPorts*BeW-1:0]       be_i;
    logic [NumPorts*DataWidth-1:0] wdata_i;
    logic [NumPorts-1:0]           rvalid_o;
    logic [NumPorts*DataWidth-1:0] rdata_o;
    logic [NumPorts-1:0]           err_o;

    logic [NumBanks-1:0]           bank_req_o;
    logic [NumBanks-1:0]           bank_we_o;
    logic [NumBanks*RowW-1:0]      bank_addr_o;
    logic [NumBanks*BeW-1:0]       bank_be_o;
    logic [NumBanks*DataWidth-1:0] bank_wdata_o;
    logic [NumBanks*DataWidth-1:0] bank_rdata_i;

    modport slave (
        input  req_i, addr_i, we_i, be_i, wdata_i, bank_rdata_i,
        output gnt_o, rvalid_o, rdata_o, err_o,
        output bank_req_o, bank_we_o, bank_addr_o, bank_be_o, bank_wdata_o
    );

    modport master (
        output req_i, addr_i, we_i, be_i, wdata_i, bank_rdata_i,
        input  gnt_o, rvalid_o, rdata_o, err_o,
        input  bank_req_o, bank_we_o, bank_addr_o, bank_be_o, bank_wdata_o
    );
endinterface

// File: rtl/l2_banked_mem_arb.sv
// ---------------------------------------------------------------------------
// l2_banked_mem_arb
// Multi-port, multi-bank L2 SRAM front-end.
//   clk_i   : clock
//   rst_ni  : synchronous active-low reset
//   mode_i  : address map, 0 = word-interleaved, 1 = contiguous
//   bus     : l2_banked_mem_arb_if.slave, requestor ports and SRAM bank ports
// Each bank has its own round-robin arbiter; grants are combinational.
// Out-of-range requests are granted at once and answered with err after
// SramLatency cycles. Responses are routed back through a per-port
// SramLatency-deep pipeline that remembers which bank to pick data from.
// ---------------------------------------------------------------------------
module l2_banked_mem_arb #(
    parameter int unsigned NumPorts    = 4,
    parameter int unsigned NumBanks    = 8,
    parameter int unsigned BankWords   = 2048,
    parameter int unsigned AddrWidth   = 32,
    parameter int unsigned DataWidth   = 64,
    parameter int unsigned SramLatency = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  mode_i,
    l2_banked_mem_arb_if.slave    bus
);
    localparam int unsigned BeW       = DataWidth / 8;
    localparam int unsigned OffBits   = $clog2(BeW);
    localparam int unsigned BankBits  = $clog2(NumBanks);
    localparam int unsigned BankIdxW  = (BankBits > 0) ? BankBits : 1;
    localparam int unsigned RowW      = $clog2(BankWords);
    localparam int unsigned PortIdxW  = (NumPorts > 1) ? $clog2(NumPorts) : 1;
    localparam int unsigned SpaceBits = BankBits + RowW;
    localparam logic [BankIdxW-1:0] BankMask = BankIdxW'(NumBanks - 1);

    // ---------------- address decode ----------------
    logic [NumPorts-1:0] w_oor;
    logic [BankIdxW-1:0] w_bank [NumPorts];
    logic [RowW-1:0]     w_row  [NumPorts];

    for (genvar gp = 0; gp < NumPorts; gp++) begin : g_dec
        logic [AddrWidth-1:0] w_wa;
        logic [AddrWidth-1:0] w_bsrc;
        logic [AddrWidth-1:0] w_rsrc;

        assign w_wa        = bus.addr_i[gp*AddrWidth +: AddrWidth] >> OffBits;
        // Total space is a power of two, so any bit above it means out of range.
        assign w_oor[gp]   = |(w_wa >> SpaceBits);
        assign w_bsrc      = mode_i ? (w_wa >> RowW) : w_wa;
        assign w_rsrc      = mode_i ? w_wa : (w_wa >> BankBits);
        assign w_bank[gp]  = w_bsrc[BankIdxW-1:0] & BankMask;
        assign w_row[gp]   = w_rsrc[RowW-1:0];
    end

    // ---------------- per-bank round-robin ----------------
    logic [PortIdxW-1:0] r_ptr [NumBanks];
    logic [NumBanks-1:0] w_bank_gnt;
    logic [PortIdxW-1:0] w_win [NumBanks];
    int unsigned         v_k;

    always_comb begin
        v_k        = 0;
        w_bank_gnt = '0;
        for (int unsigned b = 0; b < NumBanks; b++) begin
            w_win[b] = '0;
            // Scan ports starting at the pointer; the first hit wins.
            for (int unsigned i = 0; i < NumPorts; i++) begin
                v_k = (32'(r_ptr[b]) + i) % NumPorts;
                if (!w_bank_gnt[b] && bus.req_i[v_k] && !w_oor[v_k] &&
                    (w_bank[v_k] == BankIdxW'(b))) begin
                    w_bank_gnt[b] = 1'b1;
                    w_win[b]      = PortIdxW'(v_k);
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int unsigned b = 0; b < NumBanks; b++) begin
                r_ptr[b] <= '0;
            end
        end else begin
            for (int unsigned b = 0; b < NumBanks; b++) begin
                if (w_bank_gnt[b]) begin
                    r_ptr[b] <= PortIdxW'((32'(w_win[b]) + 1) % NumPorts);
                end
            end
        end
    end

    // ---------------- port grants ----------------
    logic [NumPorts-1:0] w_gnt;

    for (genvar gp = 0; gp < NumPorts; gp++) begin : g_gnt
        // Out-of-range requests bypass arbitration entirely.
        assign w_gnt[gp] = rst_ni & bus.req_i[gp] &
                           (w_oor[gp] |
                            (w_bank_gnt[w_bank[gp]] &
                             (w_win[w_bank[gp]] == PortIdxW'(gp))));
    end

    assign bus.gnt_o = w_gnt;

    // ---------------- bank outputs ----------------
    logic [NumBanks-1:0]           w_breq;
    logic [NumBanks-1:0]           w_bwe;
    logic [NumBanks*RowW-1:0]      w_baddr;
    logic [NumBanks*BeW-1:0]       w_bbe;
    logic [NumBanks*DataWidth-1:0] w_bwdata;

    always_comb begin
        w_breq   = '0;
        w_bwe    = '0;
        w_baddr  = '0;
        w_bbe    = '0;
        w_bwdata = '0;
        for (int unsigned b = 0; b < NumBanks; b++) begin
            if (rst_ni && w_bank_gnt[b]) begin
                w_breq[b]                          = 1'b1;
                w_bwe[b]                           = bus.we_i[w_win[b]];
                w_baddr[b*RowW +: RowW]            = w_row[w_win[b]];
                w_bbe[b*BeW +: BeW]                = bus.be_i[32'(w_win[b])*BeW +: BeW];
                w_bwdata[b*DataWidth +: DataWidth] =
                    bus.wdata_i[32'(w_win[b])*DataWidth +: DataWidth];
            end
        end
    end

    assign bus.bank_req_o   = w_breq;
    assign bus.bank_we_o    = w_bwe;
    assign bus.bank_addr_o  = w_baddr;
    assign bus.bank_be_o    = w_bbe;
    assign bus.bank_wdata_o = w_bwdata;

    // ---------------- response pipeline ----------------
    logic                r_v [NumPorts][SramLatency];
    logic                r_e [NumPorts][SramLatency];
    logic                r_w [NumPorts][SramLatency];
    logic [BankIdxW-1:0] r_b [NumPorts][SramLatency];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int unsigned p = 0; p < NumPorts; p++) begin
                for (int unsigned s = 0; s < SramLatency; s++) begin
                    r_v[p][s] <= 1'b0;
                    r_e[p][s] <= 1'b0;
                    r_w[p][s] <= 1'b0;
                    r_b[p][s] <= '0;
                end
            end
        end else begin
            for (int unsigned p = 0; p < NumPorts; p++) begin
                r_v[p][0] <= w_gnt[p];
                r_e[p][0] <= w_oor[p];
                r_w[p][0] <= bus.we_i[p];
                r_b[p][0] <= w_bank[p];
                for (int unsigned s = 1; s < SramLatency; s++) begin
                    r_v[p][s] <= r_v[p][s-1];
                    r_e[p][s] <= r_e[p][s-1];
                    r_w[p][s] <= r_w[p][s-1];
                    r_b[p][s] <= r_b[p][s-1];
                end
            end
        end
    end

    logic [NumPorts-1:0]           w_rvalid;
    logic [NumPorts-1:0]           w_err;
    logic [NumPorts*DataWidth-1:0] w_rdata;

    always_comb begin
        w_rvalid = '0;
        w_err    = '0;
        w_rdata  = '0;
        for (int unsigned p = 0; p < NumPorts; p++) begin
            w_rvalid[p] = r_v[p][SramLatency-1];
            w_err[p]    = r_v[p][SramLatency-1] & r_e[p][SramLatency-1];
            // Only successful reads return data; writes and errors return 0.
            if (r_v[p][SramLatency-1] && !r_e[p][SramLatency-1] && !r_w[p][SramLatency-1]) begin
                w_rdata[p*DataWidth +: DataWidth] =
                    bus.bank_rdata_i[32'(r_b[p][SramLatency-1])*DataWidth +: DataWidth];
            end
        end
    end

    assign bus.rvalid_o = w_rvalid;
    assign bus.err_o    = w_err;
    assign bus.rdata_o  = w_rdata;

endmodule

// File: tb/tb_l2_banked_mem_arb.sv
// ---------------------------------------------------------------------------
// tb_l2_banked_mem_arb
// Directed bench for l2_banked_mem_arb: one instance with SramLatency=1
// (dut_a) backed by a byte-enable SRAM model, one with SramLatency=3 (dut_b)
// backed by a pattern source that returns {0xB0B0_0000|bank, row}.
// ---------------------------------------------------------------------------
module tb_l2_banked_mem_arb;
    logic clk;
    logic rst_a;
    logic rst_b;
    logic mode_a;
    logic mode_b;

    int total;
    int bad;

    l2_banked_mem_arb_if #(.NumPorts(4), .NumBanks(8), .BankWords(2048),
                           .AddrWidth(32), .DataWidth(64)) bus_a ();
    l2_banked_mem_arb_if #(.NumPorts(4), .NumBanks(8), .BankWords(2048),
                           .AddrWidth(32), .DataWidth(64)) bus_b ();

    l2_banked_mem_arb #(.NumPorts(4), .NumBanks(8), .BankWords(2048),
                        .AddrWidth(32), .DataWidth(64), .SramLatency(1)) dut_a (
        .clk_i  (clk),
        .rst_ni (rst_a),
        .mode_i (mode_a),
        .bus    (bus_a)
    );

    l2_banked_mem_arb #(.NumPorts(4), .NumBanks(8), .BankWords(2048),
                        .AddrWidth(32), .DataWidth(64), .SramLatency(3)) dut_b (
        .clk_i  (clk),
        .rst_ni (rst_b),
        .mode_i (mode_b),
        .bus    (bus_b)
    );

    always #5 clk = ~clk;

    // SRAM model for dut_a: 1-cycle read latency, byte-enabled writes.
    logic [63:0] mem_a  [8][2048];
    logic [63:0] pipe_a [8];

    always @(posedge clk) begin
        for (int b = 0; b < 8; b++) begin
            if (bus_a.bank_req_o[b]) begin
                pipe_a[b] <= mem_a[b][bus_a.bank_addr_o[b*11 +: 11]];
                if (bus_a.bank_we_o[b]) begin
                    for (int y = 0; y < 8; y++) begin
                        if (bus_a.bank_be_o[b*8 + y])
                            mem_a[b][bus_a.bank_addr_o[b*11 +: 11]][y*8 +: 8] <=
                                bus_a.bank_wdata_o[b*64 + y*8 +: 8];
                    end
                end
            end
        end
    end

    always_comb begin
        for (int b = 0; b < 8; b++) bus_a.bank_rdata_i[b*64 +: 64] = pipe_a[b];
    end

    // Pattern source for dut_b: 3-cycle latency.
    logic [63:0] pipe_b [8][3];

    always @(posedge clk) begin
        for (int b = 0; b < 8; b++) begin
            pipe_b[b][0] <= bus_b.bank_req_o[b] ?
                {32'hB0B0_0000 | 32'(b), 32'(bus_b.bank_addr_o[b*11 +: 11])} : 64'h0;
            pipe_b[b][1] <= pipe_b[b][0];
            pipe_b[b][2] <= pipe_b[b][1];
        end
    end

    always_comb begin
        for (int b = 0; b < 8; b++) bus_b.bank_rdata_i[b*64 +: 64] = pipe_b[b][2];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [3:0]  cmask [8];
    logic [3:0]  cexp  [8];
    logic [31:0] baddr [3];

    initial begin
        clk    = 1'b0;
        rst_a  = 1'b0;
        rst_b  = 1'b0;
        mode_a = 1'b0;
        mode_b = 1'b0;
        total  = 0;
        bad    = 0;
        bus_a.req_i = '0; bus_a.addr_i = '0; bus_a.we_i = '0; bus_a.be_i = '0; bus_a.wdata_i = '0;
        bus_b.req_i = '0; bus_b.addr_i = '0; bus_b.we_i = '0; bus_b.be_i = '0; bus_b.wdata_i = '0;

        // ---- reset: grants forced low even with a request present ----
        bus_a.req_i = 4'b0001;
        tick();
        chk("rst_gnt", 64'(bus_a.gnt_o), 64'h0);
        chk("rst_breq", 64'(bus_a.bank_req_o), 64'h0);
        tick();
        bus_a.req_i = '0;
        tick();
        chk("rst_rvalid", 64'(bus_a.rvalid_o), 64'h0);
        chk("rst_err", 64'(bus_a.err_o), 64'h0);
        chk("rst_rdata", 64'(|bus_a.rdata_o), 64'h0);
        chk("rstb_rvalid", 64'(bus_b.rvalid_o), 64'h0);
        rst_a = 1'b1;
        rst_b = 1'b1;

        // ---- mode 0: write 0x08 (bank 1 row 0), then read it back ----
        tick();
        bus_a.req_i = 4'b0001; bus_a.we_i = 4'b0001;
        bus_a.addr_i[0 +: 32] = 32'h8;
        bus_a.be_i[0 +: 8] = 8'hFF;
        bus_a.wdata_i[0 +: 64] = 64'hDEADBEEF_CAFEF00D;
        #1;
        chk("wr_gnt", 64'(bus_a.gnt_o), 64'h1);
        chk("wr_breq", 64'(bus_a.bank_req_o), 64'h2);
        chk("wr_bwe", 64'(bus_a.bank_we_o), 64'h2);
        chk("wr_baddr", 64'(bus_a.bank_addr_o[11 +: 11]), 64'h0);
        chk("wr_bbe", 64'(bus_a.bank_be_o[8 +: 8]), 64'hFF);
        chk("wr_bwdata", bus_a.bank_wdata_o[64 +: 64], 64'hDEADBEEF_CAFEF00D);
        tick();
        bus_a.we_i = '0;
        #1;
        chk("rd_gnt", 64'(bus_a.gnt_o), 64'h1);
        chk("wr_rvalid", 64'(bus_a.rvalid_o), 64'h1);
        chk("wr_rdata", bus_a.rdata_o[0 +: 64], 64'h0);
        chk("wr_err", 64'(bus_a.err_o), 64'h0);
        tick();
        bus_a.req_i = '0;
        mode_a = 1'b1;
        #1;
        chk("rd_rvalid", 64'(bus_a.rvalid_o), 64'h1);
        chk("rd_rdata", bus_a.rdata_o[0 +: 64], 64'hDEADBEEF_CAFEF00D);
        chk("rd_err", 64'(bus_a.err_o), 64'h0);
        chk("idle_breq", 64'(bus_a.bank_req_o), 64'h0);

        // ---- mode 1: 0x4000 -> bank 1 row 0; 0x20000 -> out of range ----
        tick();
        bus_a.req_i = 4'b0100;
        bus_a.addr_i[64 +: 32] = 32'h4000;
        #1;
        chk("m1_gnt", 64'(bus_a.gnt_o), 64'h4);
        chk("m1_breq", 64'(bus_a.bank_req_o), 64'h2);
        chk("m1_baddr", 64'(bus_a.bank_addr_o[11 +: 11]), 64'h0);
        tick();
        bus_a.addr_i[64 +: 32] = 32'h20000;
        #1;
        chk("oor_gnt", 64'(bus_a.gnt_o), 64'h4);
        chk("oor_breq", 64'(bus_a.bank_req_o), 64'h0);
        chk("m1_rvalid", 64'(bus_a.rvalid_o), 64'h4);
        chk("m1_err", 64'(bus_a.err_o), 64'h0);
        tick();
        bus_a.req_i = '0;
        mode_a = 1'b0;
        #1;
        chk("oor_rvalid", 64'(bus_a.rvalid_o), 64'h4);
        chk("oor_err", 64'(bus_a.err_o), 64'h4);
        chk("oor_rdata", bus_a.rdata_o[128 +: 64], 64'h0);

        // ---- contention: all ports target bank 2 (rows 0..3) ----
        for (int p = 0; p < 4; p++) bus_a.addr_i[p*32 +: 32] = 32'h10 + 32'h40 * p;
        cmask[0] = 4'hF; cmask[1] = 4'hF; cmask[2] = 4'hF; cmask[3] = 4'hF;
        cmask[4] = 4'hF; cmask[5] = 4'hE; cmask[6] = 4'hC; cmask[7] = 4'h8;
        cexp[0]  = 4'h1; cexp[1]  = 4'h2; cexp[2]  = 4'h4; cexp[3]  = 4'h8;
        cexp[4]  = 4'h1; cexp[5]  = 4'h2; cexp[6]  = 4'h4; cexp[7]  = 4'h8;
        for (int c = 0; c < 8; c++) begin
            tick();
            bus_a.req_i = cmask[c];
            #1;
            chk($sformatf("rr_gnt%0d", c), 64'(bus_a.gnt_o), 64'(cexp[c]));
            chk($sformatf("rr_breq%0d", c), 64'(bus_a.bank_req_o), 64'h4);
            if (c > 0) chk($sformatf("rr_rvalid%0d", c), 64'(bus_a.rvalid_o), 64'(cexp[c-1]));
        end
        tick();
        bus_a.req_i = '0;
        #1;
        chk("rr_rvalid_last", 64'(bus_a.rvalid_o), 64'h8);

        // ---- parallel: ports 0..3 to banks 0..3 ----
        tick();
        for (int p = 0; p < 4; p++) bus_a.addr_i[p*32 +: 32] = 32'h8 * p;
        bus_a.req_i = 4'hF;
        #1;
        chk("par_gnt", 64'(bus_a.gnt_o), 64'hF);
        chk("par_breq", 64'(bus_a.bank_req_o), 64'h0F);
        tick();
        bus_a.req_i = '0;
        #1;
        chk("par_rvalid", 64'(bus_a.rvalid_o), 64'hF);

        // ---- SramLatency=3: 3 reads on port 1, then reset pulse ----
        baddr[0] = 32'h18; baddr[1] = 32'h58; baddr[2] = 32'h98;
        for (int i = 0; i < 3; i++) begin
            tick();
            bus_b.req_i = 4'b0010;
            bus_b.addr_i[32 +: 32] = baddr[i];
            #1;
            chk($sformatf("l3_gnt%0d", i), 64'(bus_b.gnt_o), 64'h2);
        end
        tick();
        rst_b = 1'b0;
        bus_b.addr_i[32 +: 32] = 32'h18;
        #1;
        chk("l3_rst_gnt", 64'(bus_b.gnt_o), 64'h0);
        chk("l3_rst_breq", 64'(bus_b.bank_req_o), 64'h0);
        chk("l3_first_rvalid", 64'(bus_b.rvalid_o), 64'h2);
        chk("l3_first_rdata", bus_b.rdata_o[64 +: 64], 64'hB0B0_0003_0000_0000);
        tick();
        rst_b = 1'b1;
        bus_b.req_i = '0;
        #1;
        chk("l3_post_rst0", 64'(bus_b.rvalid_o), 64'h0);
        tick();
        chk("l3_post_rst1", 64'(bus_b.rvalid_o), 64'h0);
        tick();
        chk("l3_post_rst2", 64'(bus_b.rvalid_o), 64'h0);
        tick();
        bus_b.req_i = 4'b0010;
        bus_b.addr_i[32 +: 32] = 32'h58;
        #1;
        chk("l3_new_gnt", 64'(bus_b.gnt_o), 64'h2);
        tick();
        bus_b.req_i = '0;
        #1;
        chk("l3_new_lat1", 64'(bus_b.rvalid_o), 64'h0);
        tick();
        chk("l3_new_lat2", 64'(bus_b.rvalid_o), 64'h0);
        tick();
        chk("l3_new_rvalid", 64'(bus_b.rvalid_o), 64'h2);
        chk("l3_new_rdata", bus_b.rdata_o[64 +: 64], 64'hB0B0_0003_0000_0001);
        chk("l3_new_err", 64'(bus_b.err_o), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/l2_banked_mem_arb.md
Name: l2_banked_mem_arb

Overview:
- Parametrised multi-port, multi-bank L2 SRAM front-end.
- Supersedes the fixed-geometry L2 memory instances: NumPorts requestors (PE, DMA and host paths, after the xbar and AXI-to-mem conversion) reach NumBanks SRAM cuts.
- Address mapping is runtime-selectable: word-interleaved or contiguous.
- Per-bank round-robin arbitration, fixed-latency response routing back to the requesting port, and out-of-range error responses.

Parameters:
- NumPorts, 4: number of requestor ports (>=1).
- NumBanks, 8: number of SRAM banks; power of two.
- BankWords, 2048: words per bank; power of two.
- AddrWidth, 32: byte address width.
- DataWidth, 64: word width in bits; power of two, >=8.
- SramLatency, 1: cycles from bank request to bank_rdata_i valid (>=1).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  synchronous active-low reset.
- mode_i  in  1  address mapping: 0 word-interleaved, 1 contiguous; change only while no port has req_i high or a response in flight.
- req_i  in  NumPorts  per-port request.
- gnt_o  out  NumPorts  per-port grant; request accepted this cycle.
- addr_i  in  NumPorts*AddrWidth  byte address per port.
- we_i  in  NumPorts  write enable per port.
- be_i  in  NumPorts*DataWidth/8  byte enables per port.
- wdata_i  in  NumPorts*DataWidth  write data per port.
- rvalid_o  out  NumPorts  response valid; asserted for both reads and writes.
- rdata_o  out  NumPorts*DataWidth  read data; 0 for writes and errors.
- err_o  out  NumPorts  out-of-range error, qualified by rvalid_o.
- bank_req_o  out  NumBanks  bank access strobe.
- bank_we_o  out  NumBanks  bank write enable.
- bank_addr_o  out  NumBanks*log2(BankWords)  bank row address.
- bank_be_o  out  NumBanks*DataWidth/8  bank byte enables.
- bank_wdata_o  out  NumBanks*DataWidth  bank write data.
- bank_rdata_i  in  NumBanks*DataWidth  bank read data, SramLatency cycles after bank_req_o.

Behaviour:
- Address decode:
  - wa = addr_i >> log2(DataWidth/8); the low byte-offset bits are ignored.
  - mode 0: bank = wa mod NumBanks, row = (wa / NumBanks) mod BankWords.
  - mode 1: bank = (wa / BankWords) mod NumBanks, row = wa mod BankWords.
  - wa >= NumBanks*BankWords means out of range.
- Arbitration:
  - Each bank has an independent round-robin arbiter over the ports that target it.
  - gnt_o is combinational, in the same cycle as req_i.
  - At most one grant per bank per cycle; ports targeting different banks are granted in parallel.
  - Priority pointer: after a grant to port p it becomes (p+1) mod NumPorts; it is unchanged when that bank grants nothing.
  - Ports that are not granted must hold req, addr, we, be and wdata stable until granted.
- Out-of-range requests:
  - Granted immediately; they never contend and produce no bank access.
  - Response: rvalid_o and err_o high after SramLatency cycles, rdata_o = 0.
- Response pipeline:
  - Per port, a SramLatency-deep shift register of {valid, err, we, bank index}.
  - rvalid_o[p] rises exactly SramLatency cycles after gnt_o[p].
  - rdata_o[p] = bank_rdata_i[bank] for reads, and 0 otherwise.
  - Throughput: 1 request per port per cycle, back-to-back, no bubbles.
- Bank outputs:
  - bank_req_o is high only in the grant cycle.
  - bank_we_o, bank_addr_o, bank_be_o and bank_wdata_o come from the winning port.
  - When bank_req_o is low they are 0.
- Reset (rst_ni low at a clock edge):
  - All RR pointers and pipeline stages are cleared; in-flight responses are dropped.
  - rvalid_o, err_o and rdata_o are 0 from the next cycle.
  - gnt_o and bank_req_o are forced to 0 while rst_ni is low.
- Simultaneous events: a grant and a response on the same port in the same cycle are independent and both occur.
- mode_i change with traffic in flight: only in-flight responses stay correct; new requests decode with the new mode.

Test Plan:
- Reset, then idle: all outputs 0; RR pointers 0 after 3 cycles with rst_ni low.
- Defaults, mode 0, port 0 writes addr 0x08 with be 0xFF, data 0xDEADBEEF_CAFEF00D; next cycle reads it back:
  - The write goes to bank 1, row 0.
  - The read gives rvalid_o[0] one cycle after its grant, with that data and err 0.
- Mode 1, addr 0x4000 (wa 2048): bank 1, row 0. Addr 0x20000 (wa 16384): out of range, err_o=1, rdata_o=0, and no bank_req_o.
- Ports 0-3 all request bank 2 for 8 consecutive cycles: grant order 0,1,2,3,0,1,2,3; each rvalid follows its grant by exactly 1 cycle.
- Ports 0-3 target banks 0-3 simultaneously: all four gnt_o are high in the same cycle, with 4 distinct bank_req_o.
- SramLatency=3, port 1 issues 3 back-to-back reads, then rst_ni is pulsed low for 1 cycle: no rvalid_o appears after reset; the next request is served normally with latency 3.
